// File: rtl/dc_rep_download.sv
// dc_rep_download
// Receive side of the 3-flit request/reply link. Reassembles head/body/tail
// flits into one 3*FLIT_W message for the data cache / memory controller.
// Framing violations raise a one-cycle frame_err pulse and the block
// resynchronises on its own.
//   ctrl_in: 01 head -> msg_out[3F-1:2F], 10 body -> [2F-1:F],
//            11 tail -> [F-1:0], 00 invalid.
//   dl_state: 00 IDLE, 01 BODY, 10 TAIL, 11 FULL (message held).

module dc_rep_download #(
  parameter int FLIT_W = 16
) (
  input  logic                clk,
  input  logic                rst,        // asynchronous, active-low
  input  logic [FLIT_W-1:0]   flit_in,
  input  logic [1:0]          ctrl_in,
  input  logic                v_flit_in,
  output logic                flit_rdy,
  output logic [3*FLIT_W-1:0] msg_out,
  output logic                v_msg_out,
  input  logic                msg_rdy,
  output logic                frame_err,
  output logic [1:0]          dl_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BODY = 2'b01,
    ST_TAIL = 2'b10,
    ST_FULL = 2'b11
  } state_t;

  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  localparam logic [2*FLIT_W-1:0] LOWER_ZERO = '0;

  state_t state;
  logic   accept;

  // Flow control: the only stall is while a finished message waits for the consumer.
  assign flit_rdy = (state != ST_FULL);
  assign accept   = v_flit_in && flit_rdy;
  assign dl_state = state;

  // Reassembly FSM: stores flit fields, tracks framing, holds the finished message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      msg_out   <= '0;
      v_msg_out <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: frame_err is given a default here and overridden below, so it is
      // a single-cycle pulse without any explicit clear path.
      frame_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (ctrl_in == CTRL_HEAD) begin
              msg_out <= {flit_in, LOWER_ZERO};
              state   <= ST_BODY;
            end else begin
              // Stray body/tail/invalid flit: nothing to discard, just flag it.
              frame_err <= 1'b1;
            end
          end
        end

        ST_BODY: begin
          if (accept) begin
            case (ctrl_in)
              CTRL_BODY: begin
                msg_out[2*FLIT_W-1:FLIT_W] <= flit_in;
                state                      <= ST_TAIL;
              end
              CTRL_HEAD: begin
                // A new head restarts the message rather than being dropped.
                msg_out   <= {flit_in, LOWER_ZERO};
                frame_err <= 1'b1;
              end
              default: begin
                msg_out   <= '0;
                state     <= ST_IDLE;
                frame_err <= 1'b1;
              end
            endcase
          end
        end

        ST_TAIL: begin
          if (accept) begin
            case (ctrl_in)
              CTRL_TAIL: begin
                msg_out[FLIT_W-1:0] <= flit_in;
                v_msg_out           <= 1'b1;
                state               <= ST_FULL;
              end
              CTRL_HEAD: begin
                msg_out   <= {flit_in, LOWER_ZERO};
                state     <= ST_BODY;
                frame_err <= 1'b1;
              end
              default: begin
                msg_out   <= '0;
                state     <= ST_IDLE;
                frame_err <= 1'b1;
              end
            endcase
          end
        end

        ST_FULL: begin
          // msg_out stays put; the consume edge returns to IDLE, which leaves a
          // one-cycle bubble before the next head can be taken.
          if (msg_rdy) begin
            v_msg_out <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dc_rep_download.sv
// tb_dc_rep_download
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the framing rules.

module tb_dc_rep_download;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] flit_in;
  logic [1:0]  ctrl_in;
  logic        v_flit_in;
  logic        flit_rdy;
  logic [47:0] msg_out;
  logic        v_msg_out;
  logic        msg_rdy;
  logic        frame_err;
  logic [1:0]  dl_state;

  int n_checks = 0;
  int n_errors = 0;
  string phase = "reset";

  // Reference model: collected flits of the partial message, plus held message.
  logic [15:0] m_parts[$];
  bit          m_full;
  bit          m_err;
  bit          m_known;   // msg_out value is defined by the rules
  logic [47:0] m_msg;

  dc_rep_download #(.FLIT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flit_in   (flit_in),
    .ctrl_in   (ctrl_in),
    .v_flit_in (v_flit_in),
    .flit_rdy  (flit_rdy),
    .msg_out   (msg_out),
    .v_msg_out (v_msg_out),
    .msg_rdy   (msg_rdy),
    .frame_err (frame_err),
    .dl_state  (dl_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_parts.delete();
    m_full  = 0;
    m_err   = 0;
    m_known = 1;
    m_msg   = '0;
  endtask

  // One clock edge of the framing rules.
  task automatic model_edge(input logic v, input logic [1:0] c, input logic [15:0] f,
                            input logic r);
    m_err = 0;
    if (m_full) begin
      if (r) begin
        m_full  = 0;
        m_known = 0;
      end
    end else if (v) begin
      if (c == 2'b01) begin
        if (m_parts.size() != 0) m_err = 1;
        m_parts.delete();
        m_parts.push_back(f);
        m_known = 0;
      end else if (c == 2'b10 && m_parts.size() == 1) begin
        m_parts.push_back(f);
        m_known = 0;
      end else if (c == 2'b11 && m_parts.size() == 2) begin
        m_msg   = {m_parts[0], m_parts[1], f};
        m_full  = 1;
        m_known = 1;
        m_parts.delete();
      end else begin
        m_err = 1;
        if (m_parts.size() != 0) begin
          m_msg   = '0;
          m_known = 1;
        end
        m_parts.delete();
      end
    end
  endtask

  task automatic compare_outputs();
    logic [1:0] exp_state;
    exp_state = m_full ? 2'd3 : 2'(m_parts.size());
    chk("dl_state", 48'(dl_state), 48'(exp_state));
    chk("v_msg_out", 48'(v_msg_out), 48'(m_full));
    chk("frame_err", 48'(frame_err), 48'(m_err));
    if (m_known) chk("msg_out", msg_out, m_msg);
  endtask

  task automatic step(input logic v, input logic [1:0] c, input logic [15:0] f,
                      input logic r);
    @(negedge clk);
    v_flit_in = v;
    ctrl_in   = c;
    flit_in   = f;
    msg_rdy   = r;
    #1;
    chk("flit_rdy", 48'(flit_rdy), 48'(!m_full));
    model_edge(v, c, f, r);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle_cycle();
    step(1'b0, 2'b00, 16'h0000, 1'b0);
  endtask

  initial begin
    int rand_cmd;
    logic [1:0] c;

    rst       = 1'b0;
    flit_in   = '0;
    ctrl_in   = '0;
    v_flit_in = 1'b0;
    msg_rdy   = 1'b0;
    model_reset();
    #12;
    compare_outputs();
    chk("rst_flit_rdy", 48'(flit_rdy), 48'd1);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back message, consumer always ready.
    phase = "t1";
    step(1, 2'b01, 16'h1111, 1);
    step(1, 2'b10, 16'h2222, 1);
    step(1, 2'b11, 16'h3333, 1);
    chk("t1_msg", msg_out, 48'h1111_2222_3333);
    chk("t1_full_rdy", 48'(flit_rdy), 48'd0);
    step(0, 2'b00, 16'h0000, 1);
    chk("t1_consumed", 48'(v_msg_out), 48'd0);

    // Consumer stalls for 5 cycles while the sender keeps offering a head.
    phase = "t2";
    step(1, 2'b01, 16'h1111, 0);
    step(1, 2'b10, 16'h2222, 0);
    step(1, 2'b11, 16'h3333, 0);
    for (int i = 0; i < 5; i++) step(1, 2'b01, 16'h7777, 0);
    chk("t2_held", msg_out, 48'h1111_2222_3333);
    step(1, 2'b01, 16'h7777, 1);
    step(1, 2'b01, 16'h8888, 0);
    chk("t2_next_head", 48'(dl_state), 48'd1);
    step(1, 2'b00, 16'h0000, 0);

    // Stray body in IDLE, then a clean message.
    phase = "t3";
    step(1, 2'b10, 16'hAAAA, 0);
    chk("t3_err", 48'(frame_err), 48'd1);
    step(1, 2'b01, 16'hBEEF, 0);
    step(1, 2'b10, 16'hCAFE, 0);
    step(1, 2'b11, 16'h1234, 1);
    chk("t3_msg", msg_out, 48'hBEEF_CAFE_1234);
    step(0, 2'b00, 16'h0000, 1);

    // Repeated head restarts the message.
    phase = "t4";
    step(1, 2'b01, 16'h1111, 0);
    step(1, 2'b01, 16'h4444, 0);
    step(1, 2'b10, 16'h5555, 0);
    step(1, 2'b11, 16'h6666, 0);
    chk("t4_msg", msg_out, 48'h4444_5555_6666);
    step(0, 2'b00, 16'h0000, 1);

    // Invalid ctrl mid-message discards it; gaps inside a good message are harmless.
    phase = "t5";
    step(1, 2'b01, 16'h0A0A, 0);
    step(1, 2'b10, 16'h0B0B, 0);
    step(1, 2'b00, 16'h0C0C, 0);
    chk("t5_cleared", msg_out, 48'h0);
    step(1, 2'b01, 16'h9001, 0);
    idle_cycle();
    idle_cycle();
    step(1, 2'b10, 16'h9002, 0);
    idle_cycle();
    step(1, 2'b11, 16'h9003, 0);
    chk("t5_msg", msg_out, 48'h9001_9002_9003);
    step(0, 2'b00, 16'h0000, 1);

    // Reset while waiting for the tail.
    phase = "t6";
    step(1, 2'b01, 16'hDEAD, 0);
    step(1, 2'b10, 16'hBEEF, 0);
    @(negedge clk);
    v_flit_in = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();

    // Randomized traffic, biased toward well-formed sequences.
    phase = "rand";
    for (int i = 0; i < 800; i++) begin
      rand_cmd = int'($urandom_range(0, 9));
      if (rand_cmd < 7) begin
        case (m_parts.size())
          0:       c = 2'b01;
          1:       c = 2'b10;
          default: c = 2'b11;
        endcase
      end else begin
        c = 2'($urandom_range(0, 3));
      end
      step($urandom_range(0, 3) != 0, c, 16'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
